// File: rtl/seq_detector_prog_if.sv
// Serial-detector bus: bit stream, pattern load, counter clear in; match, count and display out.
// The driver of the serial stream uses master; the detector uses slave.
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 4
);
  logic               x;
  logic               x_valid;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_in;
  logic [3:0]         len_in;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;
  logic [7:0]         seg;

  modport master (
    output x, x_valid, pat_load, pat_in, len_in, cnt_clr,
    input  match, match_cnt, cnt_sat, seg
  );

  modport slave (
    input  x, x_valid, pat_load, pat_in, len_in, cnt_clr,
    output match, match_cnt, cnt_sat, seg
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlapping matches, saturating match
// counter and a 7-segment readout of the low count nibble (dp flags the last match).
module seq_detector_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 4,
  parameter logic [MAX_LEN-1:0] PAT_RST = 8'b0000_0011,
  parameter int                 LEN_RST = 3
) (
  input logic               clk,
  input logic               reset,
  seq_detector_prog_if.slave bus
);

  typedef enum logic [0:0] {FILL = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [3:0]       MAX_LEN4 = 4'(MAX_LEN);
  localparam logic [3:0]       LEN_RST4 = 4'(LEN_RST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state_r, state_s;
  logic [MAX_LEN-1:0] pat_r, hist_r, hist_s, mask_s;
  logic [3:0]         len_r, len_clamp_s, fill_r, fill_s;
  logic               hit_s;
  logic               match_r, dp_r, sat_r;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [3:0]         nib_s;
  logic [6:0]         seg_hex_r;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  // Clamp the requested length into 1..MAX_LEN
  always_comb begin
    if (bus.len_in <= 4'd1) begin
      len_clamp_s = 4'd1;
    end else if (bus.len_in > MAX_LEN4) begin
      len_clamp_s = MAX_LEN4;
    end else begin
      len_clamp_s = bus.len_in;
    end
  end

  // Compare mask: the low len bits of history are significant
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (4'(i) < len_r);
    end
  end

  // Next history, fill, state and match; a load discards the same-cycle bit
  always_comb begin
    hist_s  = hist_r;
    fill_s  = fill_r;
    state_s = state_r;
    hit_s   = 1'b0;
    if (bus.pat_load) begin
      hist_s  = '0;
      fill_s  = 4'd0;
      state_s = FILL;
    end else if (bus.x_valid) begin
      hist_s = {hist_r[MAX_LEN-2:0], bus.x};
      fill_s = (fill_r == MAX_LEN4) ? fill_r : fill_r + 4'd1;
      case (state_r)
        FILL:    state_s = (fill_s >= len_r) ? ARMED : FILL;
        ARMED:   state_s = ARMED;
        default: state_s = FILL;
      endcase
      // ARMED here covers both steady ARMED and the FILL->ARMED sample
      hit_s = (state_s == ARMED) && ((hist_s & mask_s) == (pat_r & mask_s));
    end else begin
      hist_s  = hist_r;
      fill_s  = fill_r;
      state_s = state_r;
    end
  end

  // Counter next value: clear beats a same-cycle increment, increment saturates
  always_comb begin
    if (bus.cnt_clr) begin
      cnt_s = '0;
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  assign nib_s = 4'(cnt_s);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Pattern, history, counter and display registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r     <= PAT_RST;
      len_r     <= LEN_RST4;
      hist_r    <= '0;
      fill_r    <= 4'd0;
      match_r   <= 1'b0;
      dp_r      <= 1'b0;
      cnt_r     <= '0;
      sat_r     <= 1'b0;
      seg_hex_r <= 7'h3F;
    end else begin
      if (bus.pat_load) begin
        pat_r <= bus.pat_in;
        len_r <= len_clamp_s;
      end
      hist_r    <= hist_s;
      fill_r    <= fill_s;
      match_r   <= hit_s;
      dp_r      <= match_r;
      cnt_r     <= cnt_s;
      sat_r     <= (cnt_s == CNT_MAX);
      seg_hex_r <= hex7(nib_s);
    end
  end

  assign bus.match     = match_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cnt_sat   = sat_r;
  assign bus.seg       = {dp_r, seg_hex_r};

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: two instances (4-bit and 2-bit counters) share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(4)) ifa ();
  seq_detector_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) ifb ();

  assign ifb.x        = ifa.x;
  assign ifb.x_valid  = ifa.x_valid;
  assign ifb.pat_load = ifa.pat_load;
  assign ifb.pat_in   = ifa.pat_in;
  assign ifb.len_in   = ifa.len_in;
  assign ifb.cnt_clr  = ifa.cnt_clr;

  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: bits since last load/reset, newest at the back
  bit         q [$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_match, m_dp;
  bit         m_valid = 1'b0;
  int         m_cnt_a, m_cnt_b;

  function automatic void model_step();
    bit hit;
    hit = 1'b0;
    if (reset) begin
      q.delete();
      m_pat = 8'h03; m_len = 3; m_match = 1'b0; m_dp = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0; m_valid = 1'b1;
    end else begin
      m_dp = m_match;
      if (ifa.pat_load) begin
        q.delete();
        m_pat = ifa.pat_in;
        m_len = (ifa.len_in < 4'd2) ? 1 : ((int'(ifa.len_in) > MAX_LEN) ? MAX_LEN : int'(ifa.len_in));
      end else if (ifa.x_valid) begin
        q.push_back(ifa.x);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        if (q.size() >= m_len) begin
          hit = 1'b1;
          for (int j = 0; j < m_len; j++)
            if (q[q.size() - 1 - j] != m_pat[j]) hit = 1'b0;
        end
      end
      m_match = hit;
      if (ifa.cnt_clr) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (hit) begin
        if (m_cnt_a < 15) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [3:0] na;
    logic [1:0] nb;
    if (!m_valid) return;
    na = m_cnt_a[3:0];
    nb = m_cnt_b[1:0];
    chk("match_a", ifa.match, m_match);
    chk("cnt_a", ifa.match_cnt, m_cnt_a);
    chk("sat_a", ifa.cnt_sat, m_cnt_a == 15);
    chk("seg_a", ifa.seg, {m_dp, hex_tab[na]});
    chk("match_b", ifb.match, m_match);
    chk("cnt_b", ifb.match_cnt, m_cnt_b);
    chk("sat_b", ifb.cnt_sat, m_cnt_b == 3);
    chk("seg_b", ifb.seg, {m_dp, hex_tab[{2'b00, nb}]});
  endtask

  task automatic cyc(input bit r, input bit v, input bit xb, input bit ld = 1'b0,
                     input logic [7:0] p = 8'h00, input logic [3:0] l = 4'd0, input bit clr = 1'b0);
    reset = r; ifa.x = xb; ifa.x_valid = v; ifa.pat_load = ld;
    ifa.pat_in = p; ifa.len_in = l; ifa.cnt_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic bit_in(input bit b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    bit r, v, xb, ld, clr;
    logic [7:0] p;
    logic [3:0] l;

    // Reset state and default pattern 011
    cyc(1'b1, 1'b0, 1'b0);
    chk("rst_match", ifa.match, 1'b0);
    chk("rst_seg", ifa.seg, 8'h3F);
    chk("rst_cnt", ifa.match_cnt, 4'd0);
    bit_in(1'b0); bit_in(1'b1);
    chk("p011_early", ifa.match, 1'b0);
    bit_in(1'b1);
    chk("p011_match", ifa.match, 1'b1);
    chk("p011_cnt", ifa.match_cnt, 4'd1);
    chk("p011_seg", ifa.seg, 8'h06);
    idle();
    chk("p011_off", ifa.match, 1'b0);
    chk("p011_dp", ifa.seg, 8'h86);
    idle();
    chk("p011_seg2", ifa.seg, 8'h06);

    // Overlapping 101
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0101, 4'd3);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("ovl_m1", ifa.match, 1'b1);
    bit_in(1'b0);
    chk("ovl_gap", ifa.match, 1'b0);
    bit_in(1'b1);
    chk("ovl_m2", ifa.match, 1'b1);
    chk("ovl_cnt", ifa.match_cnt, 4'd2);

    // len_in=12 clamps to 8
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd12);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      bit_in(a5[i]);
      if (i > 0) chk("clamp_early", ifa.match, 1'b0);
      else       chk("clamp_match", ifa.match, 1'b1);
    end
    chk("clamp_cnt", ifa.match_cnt, 4'd3);

    // Saturation on the 2-bit counter, then clear beating the 6th match
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    end
    chk("sat_cnt_b", ifb.match_cnt, 2'd3);
    chk("sat_flag_b", ifb.cnt_sat, 1'b1);
    chk("sat_cnt_a", ifa.match_cnt, 4'd5);
    bit_in(1'b0); bit_in(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
    chk("clr_match", ifb.match, 1'b1);
    chk("clr_cnt_b", ifb.match_cnt, 2'd0);
    chk("clr_sat_b", ifb.cnt_sat, 1'b0);

    // Load on the completing bit discards it and empties history
    cyc(1'b1, 1'b0, 1'b0);
    bit_in(1'b0); bit_in(1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_0011, 4'd3);
    chk("ld_nomatch", ifa.match, 1'b0);
    bit_in(1'b1);
    chk("ld_fill1", ifa.match, 1'b0);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("ld_rematch", ifa.match, 1'b1);

    // Reset mid-pattern discards partial history
    cyc(1'b1, 1'b0, 1'b0);
    bit_in(1'b0); bit_in(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd2, 1'b1);
    bit_in(1'b1);
    chk("rstmid_match", ifa.match, 1'b0);
    chk("rstmid_cnt", ifa.match_cnt, 4'd0);
    chk("rstmid_seg", ifa.seg, 8'h3F);

    // Randomized traffic, mostly short patterns so matches are frequent
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 9) < 7);
      xb  = 1'($urandom);
      ld  = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 99) == 0);
      p   = 8'($urandom);
      l   = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      cyc(r, v, xb, ld, p, l, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
